comet_useq: RTL

COMET_USEQ -- requirements
Module: comet_useq

---
 rtl/comet_useq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/comet_useq.sv
// comet_useq -- microsequencer for the COMET control store.
// Selects the next microaddress (trap > RSR > JSR > sequential) and manages
// an 8-entry circular micro-subroutine stack with a sticky error flag.
// Optional feature: define USEQ_TRAP_EN to enable the microtrap path.
// Without it, utrap_h is ignored and utrap_ack_h is held low.
module comet_useq (
  input  logic        mclk_l,
  input  logic        sac_reset_h,
  input  logic        d_clk_en_h,
  input  logic [13:0] upc_next_h,
  input  logic [5:0]  but_h,
  input  logic        ibut_l,
  input  logic [5:0]  cs_addr_l,
  input  logic        utrap_h,
  output logic [13:0] upc_h,
  output logic [3:0]  ustk_depth_h,
  output logic        ustk_err_h,
  output logic        utrap_ack_h
);

  localparam logic [5:0]  BUT_JSR   = 6'h01;
  localparam logic [5:0]  BUT_RSR   = 6'h02;
  localparam logic [13:0] TRAP_ADDR = 14'h3FF0;

  logic [13:0] r_upc;
  logic [2:0]  r_sp;
  logic [3:0]  r_depth;
  logic        r_err;
  logic [13:0] r_stk [0:7];

  logic [5:0]  w_but;
  logic [13:0] w_target;
  logic        w_trap;
  logic        w_jsr;
  logic        w_rsr;
  logic        w_push;
  logic [13:0] w_push_data;
  logic        w_empty;
  logic        w_full;
  logic [2:0]  w_sp_dec;
  logic [13:0] w_next;

`ifdef USEQ_TRAP_EN
  logic r_ack;
  assign w_trap      = utrap_h;
  assign utrap_ack_h = r_ack;

  // Ack pulse: follows each taken trap by one enabled cycle
  always_ff @(posedge mclk_l) begin
    if (sac_reset_h)
      r_ack <= 1'b0;
    else if (d_clk_en_h)
      r_ack <= w_trap;
  end
`else
  logic w_unused_trap;
  assign w_unused_trap = utrap_h;
  assign w_trap        = 1'b0;
  assign utrap_ack_h   = 1'b0;
`endif

  // Decode the microword: invalid BUT collapses to a plain sequential step
  always_comb begin
    w_but       = ibut_l ? but_h : 6'h00;
    w_target    = ibut_l ? {upc_next_h[13:6], upc_next_h[5:0] | ~cs_addr_l}
                         : upc_next_h;
    w_jsr       = !w_trap && (w_but == BUT_JSR);
    w_rsr       = !w_trap && (w_but == BUT_RSR);
    w_push      = w_trap || w_jsr;
    // A trap returns to the interrupted word itself; a JSR returns past it
    w_push_data = w_trap ? r_upc : r_upc + 14'd1;
    w_empty     = (r_depth == 4'd0);
    w_full      = (r_depth == 4'd8);
    w_sp_dec    = r_sp - 3'd1;
    if (w_trap)
      w_next = TRAP_ADDR;
    else if (w_rsr)
      w_next = w_empty ? 14'h0000 : r_stk[w_sp_dec];
    else
      w_next = w_target;
  end

  // Control state: microaddress, stack pointer, depth and sticky error
  always_ff @(posedge mclk_l) begin
    if (sac_reset_h) begin
      r_upc   <= 14'h0000;
      r_sp    <= 3'd0;
      r_depth <= 4'd0;
      r_err   <= 1'b0;
    end else if (d_clk_en_h) begin
      r_upc <= w_next;
      if (w_push) begin
        // When full the pointer lands on the oldest entry, so it is overwritten
        r_sp <= r_sp + 3'd1;
        if (w_full)
          r_err <= 1'b1;
        else
          r_depth <= r_depth + 4'd1;
      end else if (w_rsr) begin
        if (w_empty)
          r_err <= 1'b1;
        else begin
          r_sp    <= w_sp_dec;
          r_depth <= r_depth - 4'd1;
        end
      end
    end
  end

  // Stack RAM: data only, no reset; underflow rule guards unwritten entries
  always_ff @(posedge mclk_l) begin
    if (!sac_reset_h && d_clk_en_h && w_push)
      r_stk[r_sp] <= w_push_data;
  end

  assign upc_h        = r_upc;
  assign ustk_depth_h = r_depth;
  assign ustk_err_h   = r_err;

endmodule
